wb_arbiter: RTL and testbench

- Write-back arbiter and pending-load scoreboard on the producer side of the register file write port.
- Merges two result streams into the single registered write port `(rd_wren, rd_addr, rd_data)`:
  - Channel A: in-order ALU/pipeline results.
  - Channel B: out-of-order load/multi-cycle responses.
- Channel A has priority. A starvation counter guarantees forward progress for channel B.
- A 32-bit scoreboard marks registers awaiting a channel-B result, for decode-stage stall logic.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_scoreboard.sv | 34 +++
 rtl/wb_arbiter.sv | 94 +++++++++
 tb/tb_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the write-back arbiter slice.
// Register file geometry, request bundle and grant encoding.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_A,
    GRANT_B
  } wb_grant_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per register.
// A new issue to a register outranks a retiring write to it.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_set_en,
  input  logic [REG_ADDR_W-1:0] i_set_rd,
  input  logic                  i_clr_en,
  input  logic [REG_ADDR_W-1:0] i_clr_rd,
  output logic [NUM_REGS-1:0]   o_pending
);

  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] nxt;

  always_comb begin
    set_vec = {{(NUM_REGS-1){1'b0}}, i_set_en} << i_set_rd;
    clr_vec = {{(NUM_REGS-1){1'b0}}, i_clr_en} << i_clr_rd;
    nxt     = (o_pending & ~clr_vec) | set_vec;
    nxt[0]  = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pending <= '0;
    end else begin
      o_pending <= nxt;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges in-order (A) and out-of-order (B)
// results onto the register file write port, A first.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_a_valid,
  input  logic [REG_ADDR_W-1:0] i_a_rd,
  input  logic [XLEN-1:0]       i_a_data,
  output logic                  o_a_ready,
  input  logic                  i_b_valid,
  input  logic [REG_ADDR_W-1:0] i_b_rd,
  input  logic [XLEN-1:0]       i_b_data,
  output logic                  o_b_ready,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  output logic                  o_rd_wren,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data,
  output logic [NUM_REGS-1:0]   o_pending
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt;
  logic             b_forced;
  wb_grant_e        grant;
  wb_req_t          req_sel;

  // B has waited its full budget and still wants the port.
  assign b_forced = (cnt == CNT_MAX) && i_b_valid;

  always_comb begin
    grant = GRANT_NONE;
    unique case (1'b1)
      b_forced:
        grant = GRANT_B;
      !b_forced && i_a_valid:
        grant = GRANT_A;
      !b_forced && !i_a_valid && i_b_valid:
        grant = GRANT_B;
      default:
        grant = GRANT_NONE;
    endcase
  end

  assign o_a_ready = !b_forced;
  assign o_b_ready = (grant == GRANT_B);

  always_comb begin
    req_sel.rd   = i_a_rd;
    req_sel.data = i_a_data;
    if (grant == GRANT_B) begin
      req_sel.rd   = i_b_rd;
      req_sel.data = i_b_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
      cnt       <= '0;
    end else begin
      o_rd_wren <= (grant != GRANT_NONE) &&
                   (req_sel.rd != '0);
      if (grant != GRANT_NONE) begin
        o_rd_addr <= req_sel.rd;
        o_rd_data <= req_sel.data;
      end
      if (grant == GRANT_B || !i_b_valid) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  wb_scoreboard u_sb (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_set_en  (i_issue_valid && (i_issue_rd != '0)),
    .i_set_rd  (i_issue_rd),
    .i_clr_en  (grant == GRANT_B),
    .i_clr_rd  (i_b_rd),
    .o_pending (o_pending)
  );

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed steps plus random traffic
// checked against a rule-level model of the write port.
module tb_wb_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0;
  logic [4:0]  a_rd = '0;
  logic [31:0] a_data = '0;
  logic        a_ready;
  logic        b_valid = 1'b0;
  logic [4:0]  b_rd = '0;
  logic [31:0] b_data = '0;
  logic        b_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        rd_wren;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [31:0] pending;

  int n_assert = 0;
  int n_fail   = 0;

  int          m_wait;
  logic [31:0] m_pend;
  logic        m_wren;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_a_go;
  bit          m_b_go;
  bit          a_hold;
  bit          b_hold;

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_a_valid     (a_valid),
    .i_a_rd        (a_rd),
    .i_a_data      (a_data),
    .o_a_ready     (a_ready),
    .i_b_valid     (b_valid),
    .i_b_rd        (b_rd),
    .i_b_data      (b_data),
    .o_b_ready     (b_ready),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .o_rd_wren     (rd_wren),
    .o_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_pending     (pending)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0;
    m_pend = '0;
    m_wren = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One clock: readies checked mid-cycle, write port after the edge.
  task automatic cycle(input string tag);
    bit forced;
    @(negedge clk);
    forced = b_valid && (m_wait >= LIM);
    m_b_go = b_valid && (forced || !a_valid);
    m_a_go = a_valid && !forced;
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(!forced));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(m_b_go));
    @(posedge clk);
    #1;
    if (m_b_go) begin
      m_wren = (b_rd != 0);
      m_addr = b_rd;
      m_data = b_data;
    end else if (m_a_go) begin
      m_wren = (a_rd != 0);
      m_addr = a_rd;
      m_data = a_data;
    end else begin
      m_wren = 1'b0;
    end
    m_wait = (b_valid && !m_b_go) ? m_wait + 1 : 0;
    if (m_b_go) m_pend[b_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
    chk({tag, ".wren"}, 32'(rd_wren), 32'(m_wren));
    chk({tag, ".addr"}, 32'(rd_addr), 32'(m_addr));
    chk({tag, ".data"}, rd_data, m_data);
    chk({tag, ".pend"}, pending, m_pend);
  endtask

  initial begin
    model_reset();
    #1;
    chk("rst.wren", 32'(rd_wren), 32'd0);
    chk("rst.addr", 32'(rd_addr), 32'd0);
    chk("rst.data", rd_data, 32'd0);
    chk("rst.pend", pending, 32'd0);
    chk("rst.a_ready", 32'(a_ready), 32'd1);
    chk("rst.b_ready", 32'(b_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A only
    a_valid = 1'b1;
    a_rd    = 5'd5;
    a_data  = 32'hDEAD_BEEF;
    cycle("a_only");
    chk("a_only.wr", 32'(rd_wren), 32'd1);
    chk("a_only.ad", 32'(rd_addr), 32'd5);
    chk("a_only.dt", rd_data, 32'hDEAD_BEEF);
    a_valid = 1'b0;
    cycle("a_idle");
    chk("a_idle.wr", 32'(rd_wren), 32'd0);

    // Starvation of B under constant A traffic
    a_valid = 1'b1;
    a_rd    = 5'd1;
    a_data  = 32'd100;
    b_valid = 1'b1;
    b_rd    = 5'd8;
    b_data  = 32'h55;
    for (int i = 0; i < 7; i++) begin
      cycle("starve");
      if (i == LIM) begin
        chk("starve.b_addr", 32'(rd_addr), 32'd8);
        chk("starve.b_data", rd_data, 32'h55);
      end
      if (m_b_go) b_valid = 1'b0;
      if (m_a_go) begin
        a_rd   = a_rd + 5'd1;
        a_data = a_data + 32'd1;
      end
    end
    a_valid = 1'b0;

    // rd=0 consumed without a write
    b_valid = 1'b1;
    b_rd    = 5'd0;
    b_data  = 32'h1234;
    cycle("rd0");
    chk("rd0.wren", 32'(rd_wren), 32'd0);
    chk("rd0.pend0", 32'(pending[0]), 32'd0);
    b_valid = 1'b0;

    // Scoreboard set/clear ordering
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    cycle("sb_set");
    chk("sb_set.v", pending, 32'h8);
    b_valid = 1'b1;
    b_rd    = 5'd3;
    b_data  = 32'h33;
    cycle("sb_both");
    chk("sb_both.v", pending, 32'h8);
    issue_valid = 1'b0;
    cycle("sb_clr");
    chk("sb_clr.v", pending, 32'h0);
    b_valid = 1'b0;

    // Idle hold of the write port
    a_valid = 1'b1;
    a_rd    = 5'd7;
    a_data  = 32'hA5A5_A5A5;
    cycle("hold_wr");
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle("hold");
    chk("hold.wr", 32'(rd_wren), 32'd0);
    chk("hold.ad", 32'(rd_addr), 32'd7);
    chk("hold.dt", rd_data, 32'hA5A5_A5A5);

    // Random traffic, producers hold until accepted
    a_hold = 1'b0;
    b_hold = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!a_hold) begin
        a_valid = 1'($urandom_range(0, 1));
        a_rd    = 5'($urandom);
        a_data  = $urandom;
      end
      if (!b_hold) begin
        b_valid = 1'($urandom_range(0, 1));
        b_rd    = 5'($urandom);
        b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = 5'($urandom);
      cycle("rand");
      a_hold = a_valid && !m_a_go;
      b_hold = b_valid && !m_b_go;
    end
    a_valid     = 1'b0;
    b_valid     = 1'b0;
    issue_valid = 1'b0;
    cycle("drain");

    // Asynchronous reset in the middle of a transfer
    model_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    issue_valid = 1'b1;
    issue_rd    = 5'd2;
    cycle("mid_i2");
    issue_rd = 5'd4;
    cycle("mid_i4");
    chk("mid.pend", pending, 32'h14);
    issue_valid = 1'b0;
    a_valid = 1'b1;
    a_rd    = 5'd9;
    a_data  = 32'h9999;
    cycle("mid_wr");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid.wren", 32'(rd_wren), 32'd0);
    chk("mid.addr", 32'(rd_addr), 32'd0);
    chk("mid.data", rd_data, 32'd0);
    chk("mid.pend0", pending, 32'd0);
    chk("mid.a_ready", 32'(a_ready), 32'd1);
    model_reset();
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    rst_n   = 1'b1;
    cycle("post_rst");
    chk("post_rst.wr", 32'(rd_wren), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
